frame_config_loader: RTL

FRAME_CONFIG_LOADER -- requirements
Module: frame_config_loader

---
 rtl/frame_config_loader.sv | 97 +++++++++
 1 files changed

// File: rtl/frame_config_loader.sv
// frame_config_loader: streams header + NumRows data words into FrameData and fires one registered FrameStrobe bit per frame.
// Ports: CLK/reset (async, active-high); s_data/s_valid/s_ready word stream in;
// FrameData row words and FrameStrobe column/frame strobes out; busy (not IDLE),
// err (one-cycle pulse on a rejected header), frame_count (frames strobed since reset).
module frame_config_loader #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows = 4,
  parameter int NumCols = 4
) (
  input  logic                                 CLK,
  input  logic                                 reset,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
  output logic                                 busy,
  output logic                                 err,
  output logic [15:0]                          frame_count
);
  localparam int RW = NumRows > 1 ? $clog2(NumRows) : 1;
  localparam int SW = NumCols * MaxFramesPerCol > 1 ? $clog2(NumCols * MaxFramesPerCol) : 1;
  typedef enum logic [1:0] {IDLE, DATA, STROBE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] col_q, col_d, frm_q, frm_d, idx;
  logic [NumRows*FrameBitsPerRow-1:0] data_q, data_d;
  logic [NumCols*MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic acc, hdr_ok;
  assign s_ready = state_q != STROBE;
  assign busy = state_q != IDLE;
  assign acc = s_valid & s_ready;
  assign hdr_ok = s_data[31:24] == 8'hFA && s_data[23:16] < 8'(NumCols) && s_data[15:8] < 8'(MaxFramesPerCol);
  assign idx = col_q * SW'(MaxFramesPerCol) + frm_q;
  assign FrameData = data_q;
  assign FrameStrobe = strobe_q;
  assign err = err_q;
  assign frame_count = cnt_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    frm_d = frm_q;
    data_d = data_q;
    strobe_d = '0;
    err_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (acc) begin
        if (hdr_ok) begin
          state_d = DATA;
          row_d = '0;
          col_d = SW'(s_data[23:16]);
          frm_d = SW'(s_data[15:8]);
        end else err_d = 1'b1;
      end
      DATA: if (acc) begin
        data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
        row_d = row_q + RW'(1);
        // strobe is loaded on the last word's edge so it is high exactly during STROBE
        if (row_q == RW'(NumRows - 1)) begin
          state_d = STROBE;
          strobe_d[idx] = 1'b1;
        end
      end
      STROBE: begin
        state_d = IDLE;
        cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      frm_q <= '0;
      data_q <= '0;
      strobe_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      frm_q <= frm_d;
      data_q <= data_d;
      strobe_q <= strobe_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
